// File: rtl/reg_cpu_xbar.sv
// CPU register-bus fan-out: routes one CPU register request to one of NUM_SLV
// register-bank slaves by upper address bits, with decode-error and timeout responses.
module reg_cpu_xbar #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 32,
  parameter int unsigned NUM_SLV  = 4,
  parameter int unsigned SLV_AW   = 12,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [DW-1:0]         cpu_wdata,
  input  logic [DW/8-1:0]       cpu_be,
  output logic                  cpu_ack,
  output logic [DW-1:0]         cpu_rdata,
  output logic                  cpu_err,
  output logic [NUM_SLV-1:0]    slv_req,
  output logic                  slv_we,
  output logic [SLV_AW-1:0]     slv_addr,
  output logic [DW-1:0]         slv_wdata,
  output logic [DW/8-1:0]       slv_be,
  input  logic [NUM_SLV-1:0]    slv_ack,
  input  logic [NUM_SLV*DW-1:0] slv_rdata,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      stat_timeout_cnt
);

  localparam int unsigned IDX_W    = AW - SLV_AW;
  localparam int unsigned CMP_W    = IDX_W + 5;
  localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [DW-1:0] ERR_VAL = DW'(ERR_DATA);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [IDX_W-1:0]  cpu_idx;
  logic              dec_hit;
  logic              sel_ack;
  logic              tmo_hit;
  logic [DW-1:0]     sel_rdata;

  assign cpu_idx = cpu_addr[AW-1:SLV_AW];

  // Decode, selected-slave ack/data (slv_req is one-hot on the target during WAIT)
  always_comb begin
    dec_hit   = CMP_W'(cpu_idx) < CMP_W'(NUM_SLV);
    sel_ack   = |(slv_ack & slv_req);
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (slv_req[i]) sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
    end
    tmo_hit   = (TIMEOUT != 0) && (timer == TMR_W'(TMO_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      cpu_ack          <= 1'b0;
      cpu_err          <= 1'b0;
      cpu_rdata        <= '0;
      slv_req          <= '0;
      slv_we           <= 1'b0;
      slv_addr         <= '0;
      slv_wdata        <= '0;
      slv_be           <= '0;
      stat_timeout_cnt <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (dec_hit) begin
              slv_req   <= NUM_SLV'(1) << cpu_idx;
              slv_we    <= cpu_we;
              slv_addr  <= cpu_addr[SLV_AW-1:0];
              slv_wdata <= cpu_wdata;
              slv_be    <= cpu_be;
              timer     <= '0;
              state     <= WAIT;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= cpu_we ? '0 : ERR_VAL;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          // A slave ack in the timeout cycle still completes normally
          if (sel_ack) begin
            slv_req   <= '0;
            cpu_ack   <= 1'b1;
            cpu_rdata <= slv_we ? '0 : sel_rdata;
            state     <= RESP;
          end else if (tmo_hit) begin
            slv_req   <= '0;
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= slv_we ? '0 : ERR_VAL;
            state     <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Saturating timeout statistic; clear takes priority over a coincident increment
      if (stat_clr) begin
        stat_timeout_cnt <= '0;
      end else if ((state == WAIT) && !sel_ack && tmo_hit && (stat_timeout_cnt != '1)) begin
        stat_timeout_cnt <= stat_timeout_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_cpu_xbar.sv
// Directed bench for reg_cpu_xbar: transaction-level expectation tables per cycle,
// a per-cycle compare process, and literal spot checks.
module tb_reg_cpu_xbar;

  localparam int unsigned TMO   = 8;
  localparam int unsigned NCYC  = 1024;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [15:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_be = '0;
  logic [3:0]   slv_ack = '0;
  logic [127:0] slv_rdata = '0;
  logic         stat_clr = 1'b0;
  logic         cpu_ack;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [3:0]   slv_req;
  logic         slv_we;
  logic [11:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_be;
  logic [1:0]   stat_cnt;

  // Second instance with three slaves for the decode-miss boundary
  logic         m_req = 1'b0;
  logic         m_we = 1'b0;
  logic [15:0]  m_addr = '0;
  logic [31:0]  m_wdata = '0;
  logic [3:0]   m_be = '0;
  logic [2:0]   m_slv_ack = '0;
  logic [95:0]  m_slv_rdata = '0;
  logic         m_clr = 1'b0;
  logic         m_ack;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [2:0]   m_slv_req;
  logic         m_slv_we;
  logic [11:0]  m_slv_addr;
  logic [31:0]  m_slv_wdata;
  logic [3:0]   m_slv_be;
  logic [15:0]  m_stat;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bit        exp_ack  [NCYC];
  bit        exp_err  [NCYC];
  bit [31:0] exp_rd   [NCYC];
  bit [3:0]  exp_req  [NCYC];
  bit        exp_we   [NCYC];
  bit [11:0] exp_addr [NCYC];
  bit [31:0] exp_wd   [NCYC];
  bit [3:0]  exp_be   [NCYC];
  bit        exp_tmo  [NCYC];
  logic [31:0] m_rd = '0;
  logic [1:0]  m_st = '0;

  reg_cpu_xbar #(.AW(16), .DW(32), .NUM_SLV(4), .SLV_AW(12), .TIMEOUT(TMO),
                 .ERR_DATA(ERRD), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_be(slv_be), .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .stat_clr(stat_clr), .stat_timeout_cnt(stat_cnt));

  reg_cpu_xbar #(.AW(16), .DW(32), .NUM_SLV(3), .SLV_AW(12), .TIMEOUT(TMO),
                 .ERR_DATA(ERRD), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .cpu_req(m_req), .cpu_we(m_we), .cpu_addr(m_addr),
    .cpu_wdata(m_wdata), .cpu_be(m_be), .cpu_ack(m_ack), .cpu_rdata(m_rdata),
    .cpu_err(m_err), .slv_req(m_slv_req), .slv_we(m_slv_we), .slv_addr(m_slv_addr),
    .slv_wdata(m_slv_wdata), .slv_be(m_slv_be), .slv_ack(m_slv_ack), .slv_rdata(m_slv_rdata),
    .stat_clr(m_clr), .stat_timeout_cnt(m_stat));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the expectation tables, then advance the small state model
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_ack[cyc]) m_rd = exp_rd[cyc];
      chk("cpu_ack", 64'(cpu_ack), 64'(exp_ack[cyc]));
      chk("cpu_err", 64'(cpu_err), 64'(exp_err[cyc]));
      chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rd));
      chk("slv_req", 64'(slv_req), 64'(exp_req[cyc]));
      if (exp_req[cyc] != 4'b0) begin
        chk("slv_we", 64'(slv_we), 64'(exp_we[cyc]));
        chk("slv_addr", 64'(slv_addr), 64'(exp_addr[cyc]));
        chk("slv_wdata", 64'(slv_wdata), 64'(exp_wd[cyc]));
        chk("slv_be", 64'(slv_be), 64'(exp_be[cyc]));
      end
      chk("stat_cnt", 64'(stat_cnt), 64'(m_st));
      if (!rst_n) begin
        m_st = '0;
        m_rd = '0;
      end else if (stat_clr) begin
        m_st = '0;
      end else if (exp_tmo[cyc] && m_st != 2'd3) begin
        m_st = m_st + 2'd1;
      end
    end
  end

  // One CPU transaction. k>0: target acks in the k-th slv_req cycle; k=0: target never acks.
  // spur>=0 drives a spurious ack on that slave in the first slv_req cycle; clr_r pulses stat_clr.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int k, input logic [31:0] srd,
                     input int spur, input int clr_r);
    int c0, idx, done, nreq;
    bit hit;
    c0   = cyc;
    idx  = int'(addr[15:12]);
    hit  = idx < 4;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    if (!hit) begin
      done = 1; nreq = 0;
      exp_err[c0+done] = 1'b1;
      exp_rd[c0+done]  = we ? 32'h0 : ERRD;
    end else if (k > 0) begin
      done = k + 1; nreq = k;
      exp_err[c0+done] = 1'b0;
      exp_rd[c0+done]  = we ? 32'h0 : srd;
    end else begin
      done = TMO + 1; nreq = TMO;
      exp_tmo[c0+TMO]  = 1'b1;
      exp_err[c0+done] = 1'b1;
      exp_rd[c0+done]  = we ? 32'h0 : ERRD;
    end
    exp_ack[c0+done] = 1'b1;
    for (int r = 1; r <= nreq; r++) begin
      exp_req[c0+r]  = 4'(1 << idx);
      exp_we[c0+r]   = we;
      exp_addr[c0+r] = addr[11:0];
      exp_wd[c0+r]   = wd;
      exp_be[c0+r]   = be;
    end
    for (int r = 1; r <= done + 1; r++) begin
      @(posedge clk); #1;
      slv_ack = '0;
      slv_rdata = '0;
      stat_clr = (r == clr_r);
      if (hit && k > 0 && r == k) begin
        slv_ack[idx] = 1'b1;
        slv_rdata[idx*32 +: 32] = srd;
      end
      if (spur >= 0 && r == 1) begin
        slv_ack[spur] = 1'b1;
        slv_rdata[spur*32 +: 32] = 32'hFFFF_FFFF;
      end
      if (r == done + 1) cpu_req = 1'b0;
    end
    stat_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      slv_ack = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_slv_req", 64'(slv_req), 64'h0);
    chk("reset_stat", 64'(stat_cnt), 64'h0);
    idle(2);

    // Read hit, slave 1 acks in the 4th slv_req cycle
    txn(1'b0, 16'h1004, 32'h0, 4'hF, 4, 32'hA5A5_0001, -1, 0);
    chk("hit_rdata_lit", 64'(cpu_rdata), 64'hA5A5_0001);
    chk("hit_addr_lit", 64'(slv_addr), 64'h004);
    idle(2);

    // Partial write to slave 3
    txn(1'b1, 16'h3010, 32'h1122_3344, 4'b0110, 2, 32'h5555_5555, -1, 0);
    chk("wr_be_lit", 64'(slv_be), 64'h6);
    chk("wr_wdata_lit", 64'(slv_wdata), 64'h1122_3344);
    chk("wr_rdata_lit", 64'(cpu_rdata), 64'h0);
    idle(1);

    // Decode misses on the 4-slave instance (idx 4 and 15)
    txn(1'b0, 16'h4000, 32'h0, 4'hF, 1, 32'h0, -1, 0);
    chk("miss_rd_lit", 64'(cpu_rdata), 64'hDEAD_BEEF);
    txn(1'b1, 16'hF000, 32'h9999_0000, 4'hF, 1, 32'h0, -1, 0);
    idle(1);

    // Timeout on slave 2 followed by a late ack that must be ignored
    txn(1'b0, 16'h2008, 32'h0, 4'hF, 0, 32'h0, -1, 0);
    chk("tmo_stat_lit", 64'(stat_cnt), 64'h1);
    chk("tmo_rdata_lit", 64'(cpu_rdata), 64'hDEAD_BEEF);
    @(posedge clk); #1 slv_ack[2] = 1'b1; slv_rdata[95:64] = 32'h1234_5678;
    idle(3);

    // Ack in the same cycle the timer expires: ack wins
    txn(1'b0, 16'h2000, 32'h0, 4'hF, TMO, 32'h600D_0008, -1, 0);
    chk("ack_vs_tmo_stat_lit", 64'(stat_cnt), 64'h1);
    idle(1);

    // Back-to-back zero-wait reads, spurious ack on slave 0 during the slave-3 access
    for (int i = 0; i < 4; i++)
      txn(1'b0, 16'(i * 4096 + 8), 32'h0, 4'hF, 1, 32'hC0DE_0000 + 32'(i), (i == 3) ? 0 : -1, 0);
    chk("b2b_rdata_lit", 64'(cpu_rdata), 64'hC0DE_0003);
    idle(2);

    // Reset while waiting on slave 2
    c0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2010; cpu_wdata = 32'h0; cpu_be = 4'hF;
    for (int r = 1; r <= 2; r++) begin
      exp_req[c0+r] = 4'b0100; exp_we[c0+r] = 1'b0; exp_addr[c0+r] = 12'h010;
      exp_wd[c0+r] = 32'h0; exp_be[c0+r] = 4'hF;
    end
    idle(1);
    idle(1); rst_n = 1'b0;
    idle(1); rst_n = 1'b1; cpu_req = 1'b0;
    chk("rst_req_lit", 64'(slv_req), 64'h0);
    chk("rst_ack_lit", 64'(cpu_ack), 64'h0);
    chk("rst_stat_lit", 64'(stat_cnt), 64'h0);
    idle(1); slv_ack[2] = 1'b1; slv_rdata[95:64] = 32'hABCD_0000;
    idle(3);

    // Five timeouts saturate a 2-bit counter
    for (int i = 0; i < 5; i++) txn(1'b0, 16'h2000, 32'h0, 4'hF, 0, 32'h0, -1, 0);
    chk("sat_stat_lit", 64'(stat_cnt), 64'h3);
    // Clear coincident with a timeout increment
    txn(1'b0, 16'h1000, 32'h0, 4'hF, 0, 32'h0, -1, TMO);
    chk("clr_stat_lit", 64'(stat_cnt), 64'h0);
    idle(2);

    // Three-slave instance: 0x3000 is a decode miss answered in cycle 1
    m_req = 1'b1; m_we = 1'b0; m_addr = 16'h3000; m_be = 4'hF;
    @(negedge clk);
    chk("m_ack_c0", 64'(m_ack), 64'h0);
    chk("m_req_c0", 64'(m_slv_req), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("m_ack_c1", 64'(m_ack), 64'h1);
    chk("m_err_c1", 64'(m_err), 64'h1);
    chk("m_rdata_c1", 64'(m_rdata), 64'hDEAD_BEEF);
    chk("m_req_c1", 64'(m_slv_req), 64'h0);
    @(posedge clk); #1 m_req = 1'b0;
    @(negedge clk);
    chk("m_ack_c2", 64'(m_ack), 64'h0);
    chk("m_err_c2", 64'(m_err), 64'h0);
    chk("m_req_c2", 64'(m_slv_req), 64'h0);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_cpu_xbar.md
Name: reg_cpu_xbar

Overview:
Parametrised CPU register-bus fan-out for the image pipe. It takes one CPU register master request and routes it to one of NUM_SLV register-bank slaves, selected by the upper address bits. It adds byte enables, decode-error and timeout responses, and a saturating timeout statistic. It sits between the CPU register port driven by the reg_cpu agent and the per-block register files.

Parameters:
AW, 16, CPU address width
DW, 32, data width (multiple of 8)
NUM_SLV, 4, number of slave ports (1..16)
SLV_AW, 12, slave-local address width; requires AW-SLV_AW >= clog2(NUM_SLV)
TIMEOUT, 255, cycles to wait for slave ack; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, cpu_rdata value on an errored read (truncated to DW)
CNT_W, 16, statistic counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  request valid; held with stable attributes until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  byte address
cpu_wdata  in  DW  write data
cpu_be  in  DW/8  byte enables
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid while cpu_ack=1
cpu_err  out  1  error flag, valid while cpu_ack=1
slv_req  out  NUM_SLV  one-hot request to the selected slave
slv_we  out  1  broadcast write strobe qualifier
slv_addr  out  SLV_AW  cpu_addr[SLV_AW-1:0], registered
slv_wdata  out  DW  registered write data
slv_be  out  DW/8  registered byte enables
slv_ack  in  NUM_SLV  per-slave completion pulse
slv_rdata  in  NUM_SLV*DW  flat read data; slave i occupies [i*DW +: DW]
stat_clr  in  1  clears stat_timeout_cnt
stat_timeout_cnt  out  CNT_W  saturating count of timed-out transactions

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. cpu_ack=0, cpu_err=0, cpu_rdata=0, slv_req=0, slv_we=0, slv_addr=0, slv_wdata=0, slv_be=0, stat_timeout_cnt=0, timer=0. Reset mid-transaction aborts the transaction with no cpu_ack; any later slv_ack is ignored.
- Decode: idx = cpu_addr[AW-1:SLV_AW]. idx >= NUM_SLV means decode miss.
- FSM states: IDLE, WAIT, RESP.
- IDLE with cpu_req=1 on a hit: register addr, wdata, be, we and idx; go to WAIT. slv_req[idx]=1 from the next cycle.
- IDLE with cpu_req=1 on a miss: go to RESP with err=1. rdata = ERR_DATA for reads, 0 for writes. No slv_req is issued.
- WAIT: slv_req[idx] is held high and the timer increments each cycle.
  - slv_ack[idx]=1 sampled: latch rdata = slv_rdata[idx] for reads (0 for writes), err=0, drop slv_req next cycle, go to RESP.
  - Timer reaches TIMEOUT without ack (TIMEOUT>0): drop slv_req, err=1, rdata per the miss rule, stat_timeout_cnt += 1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- slv_ack on a non-selected slave, or any slv_ack outside WAIT, is ignored.
- RESP: cpu_ack=1 for exactly one cycle with cpu_rdata/cpu_err; then go to IDLE. cpu_rdata holds its value until the next RESP; cpu_err is 0 outside RESP.
- The CPU changes or drops cpu_req in the cycle after cpu_ack. IDLE samples a new request immediately, so back-to-back spacing is 1 IDLE cycle.
- Latency on a hit: req sampled in cycle 0; slv_req high in cycles 1..k; slave acks in cycle k; cpu_ack in cycle k+1. With a zero-wait slave (ack in cycle 1), cpu_ack is in cycle 2.
- Latency on a miss: cpu_ack in cycle 1.
- Latency on a timeout: cpu_ack in cycle TIMEOUT+1.
- stat_timeout_cnt saturates at 2^CNT_W-1. If stat_clr coincides with an increment, the result is 0 (clear wins).
- slv_we, slv_addr, slv_wdata and slv_be are meaningful only while any slv_req bit is high; they hold their last value otherwise.

Test Plan:
- Read hit: cpu_addr=0x1004, slave 1 acks 3 cycles after slv_req with rdata 0xA5A5_0001 -> slv_req=4'b0010, slv_addr=0x004; cpu_ack one cycle later with rdata 0xA5A5_0001, err=0.
- Write with be=4'b0110 to addr 0x3010, wdata 0x1122_3344 -> slv_req=4'b1000, slv_we=1, slv_be=4'b0110, slv_wdata=0x1122_3344; cpu_ack with err=0, rdata=0.
- Decode miss: NUM_SLV=3, read at 0x3000 -> cpu_ack in cycle 1, err=1, rdata=0xDEAD_BEEF; slv_req stays 0 throughout.
- Timeout: TIMEOUT=8, slave 2 never acks -> slv_req[2] high for 8 cycles; cpu_ack in cycle 9 with err=1; stat_timeout_cnt=1. A slave-2 ack injected 2 cycles later is ignored (no second cpu_ack).
- Back-to-back: 4 reads to slaves 0..3 with zero-wait slaves, plus a spurious slv_ack[0] during a slave-3 access -> 4 acks at 3-cycle spacing with correct data; the spurious ack has no effect.
- Reset and stats: rst_n low while in WAIT -> next cycle slv_req=0, cpu_ack=0, stat_timeout_cnt=0. With CNT_W=2 and 5 timeouts -> count saturates at 3. stat_clr together with a timeout -> count reads 0.
